// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared constants for the memory fill/writeback responder: FSM state
// encoding and the default line geometry / read latency.
// No ports (package).
// -----------------------------------------------------------------------------
package mem_pkg;

    // Default number of one-byte beats per cache line (power of two).
    localparam int LINE_BEATS_DEF = 4;
    // Default cycles from read accept to the first fill beat.
    localparam int RD_LATENCY_DEF = 3;

    // FSM state encoding.
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RD_WAIT  = 3'd1;
    localparam logic [2:0] ST_RD_BURST = 3'd2;
    localparam logic [2:0] ST_WR_BURST = 3'd3;
    localparam logic [2:0] ST_WR_ACK   = 3'd4;

endpackage

// File: rtl/mem_byte_array.sv
// -----------------------------------------------------------------------------
// mem_byte_array
// Backing store: 2^AW words of DW bits, synchronous write, combinational read.
// Contents are never reset so a bench may preload them.
// Ports:
//   i_clk    - clock, write on rising edge
//   i_we     - write enable
//   i_waddr  - write address
//   i_wdata  - write data
//   i_raddr  - read address
//   o_rdata  - read data (combinational from i_raddr)
// -----------------------------------------------------------------------------
module mem_byte_array
    import mem_pkg::*;
#(
    parameter int AW = 10,
    parameter int DW = 8
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] data [0:(1 << AW) - 1];

    // Synchronous write port.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            data[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = data[i_raddr];

endmodule

// File: rtl/mem_fill_responder.sv
// -----------------------------------------------------------------------------
// mem_fill_responder
// Serves L1 line fills (reads) and writebacks (writes) against a byte array.
// A fill returns LINE_BEATS bytes in offset order RD_LATENCY cycles after the
// accept edge; a writeback absorbs LINE_BEATS bytes and pulses wr_ack once.
// Ports:
//   plusclk      - clock (rising edge)
//   rst          - asynchronous active-low reset
//   req_valid/req_ready/req_we/req_addr - request channel
//   wdata_valid/wdata/wdata_ready       - writeback beat channel
//   rsp_valid/rsp_data/rsp_last/rsp_ready - fill beat channel
//   wr_ack       - one-cycle pulse when a writeback completes
// -----------------------------------------------------------------------------
module mem_fill_responder
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 8,
    parameter int LINE_BEATS = LINE_BEATS_DEF,
    parameter int MEM_AW     = 10,
    parameter int RD_LATENCY = RD_LATENCY_DEF
) (
    input  logic                  plusclk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  wdata_valid,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  wdata_ready,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_last,
    input  logic                  rsp_ready,
    output logic                  wr_ack
);

    localparam int OFF_W  = $clog2(LINE_BEATS);
    localparam int LINE_W = MEM_AW - OFF_W;
    localparam int WAIT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    localparam logic [OFF_W-1:0]  LAST_BEAT = OFF_W'(LINE_BEATS - 1);
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(RD_LATENCY - 1);

    logic [2:0]            r_state;
    logic [LINE_W-1:0]     r_line;
    logic [OFF_W-1:0]      r_cnt;
    logic [WAIT_W-1:0]     r_wait;
    logic                  r_req_ready;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic                  r_rsp_last;
    logic                  r_wdata_ready;
    logic                  r_wr_ack;

    logic [MEM_AW-1:0]     w_req_mem_addr;
    logic [LINE_W-1:0]     w_req_line;
    logic [OFF_W-1:0]      w_cnt_nxt;
    logic                  w_mem_we;
    logic [MEM_AW-1:0]     w_mem_waddr;
    logic [MEM_AW-1:0]     w_mem_raddr;
    logic [DATA_WIDTH-1:0] w_mem_rdata;

    // Upper address bits fall away here, giving the modulo-2^MEM_AW wrap;
    // the shift drops the in-line offset so every request is line aligned.
    assign w_req_mem_addr = MEM_AW'(req_addr);
    assign w_req_line     = LINE_W'(w_req_mem_addr >> OFF_W);
    assign w_cnt_nxt      = r_cnt + OFF_W'(1);

    assign w_mem_we    = (r_state == ST_WR_BURST) && wdata_valid && r_wdata_ready;
    assign w_mem_waddr = {r_line, r_cnt};

    // Read address looks one beat ahead so the registered rsp_data is loaded
    // with the next byte on the same edge that retires the current one.
    always_comb begin
        w_mem_raddr = {r_line, {OFF_W{1'b0}}};
        if (r_state == ST_RD_BURST) begin
            w_mem_raddr = {r_line, w_cnt_nxt};
        end else begin
            w_mem_raddr = {r_line, {OFF_W{1'b0}}};
        end
    end

    mem_byte_array #(
        .AW (MEM_AW),
        .DW (DATA_WIDTH)
    ) data_mem (
        .i_clk   (plusclk),
        .i_we    (w_mem_we),
        .i_waddr (w_mem_waddr),
        .i_wdata (wdata),
        .i_raddr (w_mem_raddr),
        .o_rdata (w_mem_rdata)
    );

    // Control FSM with all handshake outputs registered.
    always_ff @(posedge plusclk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_line        <= {LINE_W{1'b0}};
            r_cnt         <= {OFF_W{1'b0}};
            r_wait        <= {WAIT_W{1'b0}};
            r_req_ready   <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= {DATA_WIDTH{1'b0}};
            r_rsp_last    <= 1'b0;
            r_wdata_ready <= 1'b0;
            r_wr_ack      <= 1'b0;
        end else begin
            r_wr_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_req_ready && req_valid) begin
                        r_req_ready <= 1'b0;
                        r_line      <= w_req_line;
                        r_cnt       <= {OFF_W{1'b0}};
                        r_wait      <= {WAIT_W{1'b0}};
                        if (req_we) begin
                            r_state       <= ST_WR_BURST;
                            r_wdata_ready <= 1'b1;
                        end else begin
                            r_state <= ST_RD_WAIT;
                        end
                    end else begin
                        // Also raises req_ready on the first edge after reset.
                        r_req_ready <= 1'b1;
                    end
                end
                ST_RD_WAIT: begin
                    if (r_wait == LAST_WAIT) begin
                        r_state     <= ST_RD_BURST;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= w_mem_rdata;
                        r_rsp_last  <= (LAST_BEAT == {OFF_W{1'b0}});
                        r_cnt       <= {OFF_W{1'b0}};
                    end else begin
                        r_wait <= r_wait + WAIT_W'(1);
                    end
                end
                ST_RD_BURST: begin
                    if (r_rsp_valid && rsp_ready) begin
                        if (r_rsp_last) begin
                            r_state     <= ST_IDLE;
                            r_rsp_valid <= 1'b0;
                            r_rsp_last  <= 1'b0;
                            r_rsp_data  <= {DATA_WIDTH{1'b0}};
                            r_cnt       <= {OFF_W{1'b0}};
                            r_req_ready <= 1'b1;
                        end else begin
                            r_cnt      <= w_cnt_nxt;
                            r_rsp_data <= w_mem_rdata;
                            r_rsp_last <= (w_cnt_nxt == LAST_BEAT);
                        end
                    end
                end
                ST_WR_BURST: begin
                    if (wdata_valid && r_wdata_ready) begin
                        if (r_cnt == LAST_BEAT) begin
                            r_state       <= ST_WR_ACK;
                            r_wdata_ready <= 1'b0;
                            r_wr_ack      <= 1'b1;
                            r_cnt         <= {OFF_W{1'b0}};
                        end else begin
                            r_cnt <= w_cnt_nxt;
                        end
                    end
                end
                ST_WR_ACK: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_cnt         <= {OFF_W{1'b0}};
                    r_wait        <= {WAIT_W{1'b0}};
                    r_req_ready   <= 1'b0;
                    r_rsp_valid   <= 1'b0;
                    r_rsp_data    <= {DATA_WIDTH{1'b0}};
                    r_rsp_last    <= 1'b0;
                    r_wdata_ready <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready   = r_req_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_data    = r_rsp_data;
    assign rsp_last    = r_rsp_last;
    assign wdata_ready = r_wdata_ready;
    assign wr_ack      = r_wr_ack;

endmodule
